// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - multi-cycle unsigned multiply/divide sequencer driving a shared Alu16
//
// Runs a 16x16 shift-add multiply or a 16/16 restoring divide, one Alu16 pass per
// step. Only the control bits and operands go out to the ALU; its sum comes back on
// i_alu_out. Alu16 does not report the adder carry, so it is rebuilt here from the
// operand and result MSBs.
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge), asynchronous active-low reset
//   i_start, i_op           request (sampled only in IDLE); 0 = multiply, 1 = divide
//   i_a, i_b                multiplicand/dividend, multiplier/divisor
//   o_busy                  high whenever not IDLE
//   o_done                  one-cycle pulse; results are valid from this cycle on
//   o_result_lo/hi          product[15:0]/[31:16] or quotient/remainder
//   o_div_by_zero           set with done for a divide by zero
//   o_alu_zx..o_alu_no      Alu16 control bits
//   o_alu_x, o_alu_y        Alu16 operands
//   i_alu_out               Alu16 result, same cycle
//   i_alu_zr, i_alu_ng      Alu16 flags, reserved
module alu_muldiv_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result_lo,
    output logic [WIDTH-1:0] o_result_hi,
    output logic             o_div_by_zero,
    output logic             o_alu_zx,
    output logic             o_alu_nx,
    output logic             o_alu_zy,
    output logic             o_alu_ny,
    output logic             o_alu_f,
    output logic             o_alu_no,
    output logic [WIDTH-1:0] o_alu_x,
    output logic [WIDTH-1:0] o_alu_y,
    input  logic [WIDTH-1:0] i_alu_out,
    input  logic             i_alu_zr,
    input  logic             i_alu_ng
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_count;
    // r_opnd holds M (multiply) or D (divide); r_hi/r_lo hold P_hi/P_lo or R/Q.
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_result_lo;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_div_by_zero;

    logic [WIDTH-1:0] w_rs;
    logic             w_ov;
    logic [WIDTH-1:0] w_y_eff;
    logic             w_carry;
    logic             w_borrow;
    logic             w_qb;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;
    logic             w_last;
    logic             w_unused;

    assign w_unused = ^{i_alu_zr, i_alu_ng};

    // Divide: remainder shifted left with the next dividend bit. The bit shifted
    // out of R is the 17th bit of Rs; if set, Rs >= D regardless of the subtract.
    assign w_rs = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
    assign w_ov = r_hi[WIDTH-1];

    // The carry must use the addend the ALU actually sees: with zy set the ALU
    // adds zero, not M.
    assign w_y_eff  = r_lo[0] ? r_opnd : '0;
    assign w_carry  = (r_hi[WIDTH-1] & w_y_eff[WIDTH-1])
                    | ((r_hi[WIDTH-1] | w_y_eff[WIDTH-1]) & ~i_alu_out[WIDTH-1]);
    assign w_borrow = (~w_rs[WIDTH-1] & r_opnd[WIDTH-1])
                    | (~(w_rs[WIDTH-1] ^ r_opnd[WIDTH-1]) & i_alu_out[WIDTH-1]);
    assign w_qb     = w_ov | ~w_borrow;

    always_comb begin
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (r_state == S_MUL) begin
            w_hi_nxt = {w_carry, i_alu_out[WIDTH-1:1]};
            w_lo_nxt = {i_alu_out[0], r_lo[WIDTH-1:1]};
        end else if (r_state == S_DIV) begin
            w_hi_nxt = w_qb ? i_alu_out : w_rs;
            w_lo_nxt = {r_lo[WIDTH-2:0], w_qb};
        end
    end

    assign w_last = (r_count == CNT_W'(WIDTH - 1));

    // ALU drive is a pure decode of state; idle passes x through (x & ~0).
    always_comb begin
        o_alu_x  = '0;
        o_alu_y  = '0;
        o_alu_zx = 1'b0;
        o_alu_nx = 1'b0;
        o_alu_zy = 1'b1;
        o_alu_ny = 1'b1;
        o_alu_f  = 1'b0;
        o_alu_no = 1'b0;
        case (r_state)
            S_MUL: begin
                o_alu_x  = r_hi;
                o_alu_y  = r_opnd;
                o_alu_zy = ~r_lo[0];
                o_alu_ny = 1'b0;
                o_alu_f  = 1'b1;
            end
            S_DIV: begin
                // ~(~x + y) = x - y
                o_alu_x  = w_rs;
                o_alu_y  = r_opnd;
                o_alu_nx = 1'b1;
                o_alu_zy = 1'b0;
                o_alu_ny = 1'b0;
                o_alu_f  = 1'b1;
                o_alu_no = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_opnd        <= '0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_result_lo   <= '0;
            r_result_hi   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_div_by_zero <= 1'b0;
                        r_count       <= '0;
                        if (!i_op) begin
                            r_opnd  <= i_a;
                            r_hi    <= '0;
                            r_lo    <= i_b;
                            r_state <= S_MUL;
                        end else if (i_b != '0) begin
                            r_opnd  <= i_b;
                            r_hi    <= '0;
                            r_lo    <= i_a;
                            r_state <= S_DIV;
                        end else begin
                            r_lo          <= {WIDTH{1'b1}};
                            r_hi          <= i_a;
                            r_result_lo   <= {WIDTH{1'b1}};
                            r_result_hi   <= i_a;
                            r_div_by_zero <= 1'b1;
                            r_state       <= S_DONE;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    r_hi    <= w_hi_nxt;
                    r_lo    <= w_lo_nxt;
                    r_count <= r_count + CNT_W'(1);
                    if (w_last) begin
                        // Results are captured on entry to DONE so they are valid
                        // in the same cycle as the done pulse.
                        r_result_lo <= w_lo_nxt;
                        r_result_hi <= w_hi_nxt;
                        r_state     <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = (r_state == S_DONE);
    assign o_result_lo   = r_result_lo;
    assign o_result_hi   = r_result_hi;
    assign o_div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - self-checking bench for alu_muldiv_seq with an Alu16 model
`timescale 1ns/1ps
module tb_alu_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result_lo;
    logic [15:0] result_hi;
    logic        div_by_zero;
    logic        zx, nx, zy, ny, f, no;
    logic [15:0] alu_x, alu_y, alu_out;
    logic        alu_zr, alu_ng;

    int total = 0;
    int bad   = 0;

    alu_muldiv_seq #(.WIDTH(16), .CNT_W(5)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_op          (op),
        .i_a           (a),
        .i_b           (b),
        .o_busy        (busy),
        .o_done        (done),
        .o_result_lo   (result_lo),
        .o_result_hi   (result_hi),
        .o_div_by_zero (div_by_zero),
        .o_alu_zx      (zx),
        .o_alu_nx      (nx),
        .o_alu_zy      (zy),
        .o_alu_ny      (ny),
        .o_alu_f       (f),
        .o_alu_no      (no),
        .o_alu_x       (alu_x),
        .o_alu_y       (alu_y),
        .i_alu_out     (alu_out),
        .i_alu_zr      (alu_zr),
        .i_alu_ng      (alu_ng)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hack-style Alu16
    always_comb begin
        logic [15:0] xx, yy, oo;
        xx = zx ? 16'h0 : alu_x;
        if (nx) xx = ~xx;
        yy = zy ? 16'h0 : alu_y;
        if (ny) yy = ~yy;
        oo = f ? (xx + yy) : (xx & yy);
        if (no) oo = ~oo;
        alu_out = oo;
        alu_zr  = (oo == 16'h0);
        alu_ng  = oo[15];
    end

    // Reference model: plain arithmetic.
    function automatic logic [32:0] model(input logic o, input logic [15:0] x, input logic [15:0] y);
        logic [31:0] p;
        if (!o) begin
            p = 32'(x) * 32'(y);
            return {1'b0, p};
        end else if (y == 16'h0) begin
            return {1'b1, x, 16'hFFFF};
        end else begin
            return {1'b0, x % y, x / y};
        end
    endfunction

    // Launch one op; returns cycles from start edge to the done cycle, or 0 on timeout.
    task automatic run_op(input logic o, input logic [15:0] x, input logic [15:0] y, output int lat);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = 1'b0; a = 16'h0; b = 16'h0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if ({result_hi, result_lo} !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", {result_hi, result_lo}); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
        total++; if ({alu_x, alu_y, zx, nx, zy, ny, f, no} !== {32'h0, 6'b001100}) begin
            bad++; $display("FAIL reset_alu_idle got=%h/%h/%b want=0/0/001100", alu_x, alu_y, {zx, nx, zy, ny, f, no});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [15:0] ta [5] = '{16'd3, 16'hFFFF, 16'd100, 16'hFFFF, 16'h1234};
        logic [15:0] tb [5] = '{16'd5, 16'hFFFF, 16'd7,   16'h8001, 16'h0};
        logic        to [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [32:0] want [5] = '{{1'b0, 32'h0000_000F}, {1'b0, 32'hFFFE_0001},
                                  {1'b0, 16'd2, 16'd14}, {1'b0, 16'h7FFE, 16'h0001},
                                  {1'b1, 16'h1234, 16'hFFFF}};
        int          wlat [5] = '{17, 17, 17, 17, 1};
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(to[i], ta[i], tb[i], lat);
            total++; if (lat != wlat[i]) begin bad++; $display("FAIL directed%0d_latency got=%0d want=%0d", i, lat, wlat[i]); end
            total++; if ({div_by_zero, result_hi, result_lo} !== want[i]) begin
                bad++; $display("FAIL directed%0d_result got=%b/%h/%h want=%h", i, div_by_zero, result_hi, result_lo, want[i]);
            end
        end
        // Results hold once the sequencer is idle again.
        repeat (3) @(negedge clk);
        total++; if ({busy, done, result_hi, result_lo} !== {2'b00, 32'h1234_FFFF}) begin
            bad++; $display("FAIL hold_after_done got=%b%b/%h/%h want=00/1234/ffff", busy, done, result_hi, result_lo);
        end
    endtask

    task automatic test_ignore_start();
        int lat = 0;
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 16'h1234; b = 16'h5678;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (done) begin lat = n; break; end
            if (n == 5) begin start = 1'b1; op = 1'b1; a = 16'd99; b = 16'd3; end
            if (n == 6) start = 1'b0;
            if (n >= 7) begin a = 16'($urandom); b = 16'($urandom); end
            @(negedge clk);
        end
        total++; if (lat != 17) begin bad++; $display("FAIL ignore_start_latency got=%0d want=17", lat); end
        total++; if ({result_hi, result_lo} !== 32'h0626_0060) begin
            bad++; $display("FAIL ignore_start_result got=%h%h want=06260060", result_hi, result_lo);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int lat;
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 16'hABCD; b = 16'h1357;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if ({busy, done, div_by_zero, result_hi, result_lo} !== 35'h0) begin
            bad++; $display("FAIL reset_mid_async got=%b%b%b/%h/%h want=all zero", busy, done, div_by_zero, result_hi, result_lo);
        end
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (n == 3) rst_n = 1'b1;
            if (done) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL reset_mid_no_done got=%0d want=0", seen); end
        run_op(1'b0, 16'hABCD, 16'h1357, lat);
        total++; if (lat != 17 || {result_hi, result_lo} !== 32'(32'hABCD * 32'h1357)) begin
            bad++; $display("FAIL reset_mid_fresh got=%0d/%h%h want=17/%h", lat, result_hi, result_lo, 32'(32'hABCD * 32'h1357));
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(1'b1, 16'd55, 16'd0, lat);
        total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL b2b_dbz_set got=%b want=1", div_by_zero); end
        // Next start goes in the very first IDLE cycle; flag must drop once it is accepted.
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 16'd9; b = 16'd9;
        @(negedge clk);
        start = 1'b0;
        total++; if ({busy, div_by_zero} !== 2'b10) begin
            bad++; $display("FAIL b2b_dbz_clear got=%b%b want=10", busy, div_by_zero);
        end
        total++; if ({result_hi, result_lo} !== {16'd55, 16'hFFFF}) begin
            bad++; $display("FAIL b2b_prev_hold got=%h%h want=0037ffff", result_hi, result_lo);
        end
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            if (done) begin lat = n; break; end
            @(negedge clk);
        end
        total++; if (lat != 17 || {div_by_zero, result_hi, result_lo} !== {1'b0, 32'd81}) begin
            bad++; $display("FAIL b2b_second got=%0d/%b/%h%h want=17/0/00000051", lat, div_by_zero, result_hi, result_lo);
        end
    endtask

    task automatic test_random();
        int lat;
        logic        o;
        logic [15:0] x, y;
        logic [32:0] w;
        for (int i = 0; i < 40; i++) begin
            o = 1'($urandom);
            x = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       y = 16'h0;
                1:       y = 16'hFFFF;
                2:       y = 16'($urandom_range(1, 15));
                default: y = 16'($urandom);
            endcase
            if (i < 4) x = 16'hFFFF;
            w = model(o, x, y);
            run_op(o, x, y, lat);
            total++; if (lat != ((o && y == 16'h0) ? 1 : 17)) begin
                bad++; $display("FAIL rand%0d_latency op=%b a=%h b=%h got=%0d", i, o, x, y, lat);
            end
            total++; if ({div_by_zero, result_hi, result_lo} !== w) begin
                bad++; $display("FAIL rand%0d_result op=%b a=%h b=%h got=%b/%h/%h want=%h", i, o, x, y, div_by_zero, result_hi, result_lo, w);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
